// File: rtl/scalar_memory_bp.sv
// Two-port byte-masked scalar memory with per-port 2-entry response FIFOs.
// Reads and write acks are captured straight into the FIFO at acceptance.
module scalar_memory_bp #(
  parameter  int DWIDTH = 32,
  parameter  int AWIDTH = 13,
  parameter  int DEPTH  = 8192,
  parameter  int WR_ACK = 0,
  localparam int NLANES = DWIDTH / 8,
  localparam int LSB    = $clog2(NLANES)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              t0_valid,
  output logic              t0_ready,
  input  logic              t0_we,
  input  logic [NLANES-1:0] t0_mask,
  input  logic [31:0]       t0_addr,
  input  logic [DWIDTH-1:0] t0_data,
  output logic              i0_valid,
  input  logic              i0_ready,
  output logic [DWIDTH-1:0] i0_data,
  input  logic              t1_valid,
  output logic              t1_ready,
  input  logic              t1_we,
  input  logic [NLANES-1:0] t1_mask,
  input  logic [31:0]       t1_addr,
  input  logic [DWIDTH-1:0] t1_data,
  output logic              i1_valid,
  input  logic              i1_ready,
  output logic [DWIDTH-1:0] i1_data
);

  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              vld   [2];
  logic              we    [2];
  logic [NLANES-1:0] msk   [2];
  logic [AWIDTH-1:0] wa    [2];
  logic [DWIDTH-1:0] wd    [2];
  logic              irdy  [2];
  logic              rdy   [2];
  logic              acc   [2];
  logic              inr   [2];
  logic              wr    [2];
  logic              ivld  [2];
  logic [DWIDTH-1:0] idata [2];
  logic [DWIDTH-1:0] resp  [2];
  logic              unused_addr;

  assign vld[0]  = t0_valid;
  assign vld[1]  = t1_valid;
  assign we[0]   = t0_we;
  assign we[1]   = t1_we;
  assign msk[0]  = t0_mask;
  assign msk[1]  = t1_mask;
  assign wa[0]   = t0_addr[AWIDTH+LSB-1:LSB];
  assign wa[1]   = t1_addr[AWIDTH+LSB-1:LSB];
  assign wd[0]   = t0_data;
  assign wd[1]   = t1_data;
  assign irdy[0] = i0_ready;
  assign irdy[1] = i1_ready;

  assign t0_ready = rdy[0];
  assign t1_ready = rdy[1];
  assign i0_valid = ivld[0];
  assign i1_valid = ivld[1];
  assign i0_data  = idata[0];
  assign i1_data  = idata[1];

  assign unused_addr = ^{t0_addr, t1_addr};

  function automatic logic [DWIDTH-1:0] lane_merge(input logic [DWIDTH-1:0] base,
                                                   input logic [DWIDTH-1:0] wdata,
                                                   input logic [NLANES-1:0] m);
    logic [DWIDTH-1:0] r;
    r = base;
    for (int i = 0; i < NLANES; i++) begin
      if (m[i]) r[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return r;
  endfunction

  // Port 0 is applied last so it wins on lanes both ports write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANES; i++) begin
      if (wr[1] && msk[1][i]) mem[wa[1]][i*8 +: 8] <= wd[1][i*8 +: 8];
      if (wr[0] && msk[0][i]) mem[wa[0]][i*8 +: 8] <= wd[0][i*8 +: 8];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DWIDTH-1:0] ent_q [2];
    logic [1:0]        occ_q, occ_d;
    logic              head_q, head_d;
    logic              tail, push, pop;
    logic [DWIDTH-1:0] old_w, post_w;

    assign ivld[p]  = (occ_q != 2'd0);
    assign idata[p] = ivld[p] ? ent_q[head_q] : '0;
    assign rdy[p]   = (we[p] && (WR_ACK == 0)) || (occ_q < 2'd2) || (ivld[p] && irdy[p]);
    assign acc[p]   = vld[p] && rdy[p];
    assign inr[p]   = ({1'b0, wa[p]} < DEPTH_W);
    assign wr[p]    = acc[p] && we[p] && inr[p];
    assign push     = acc[p] && (!we[p] || (WR_ACK != 0));
    assign pop      = ivld[p] && irdy[p];
    assign tail     = head_q ^ occ_q[0];
    assign head_d   = head_q ^ pop;

    // Reads see pre-write memory; write acks see the merged post-write word.
    always_comb begin
      old_w  = inr[p] ? mem[wa[p]] : '0;
      post_w = old_w;
      if (wr[1] && (wa[1] == wa[p])) post_w = lane_merge(post_w, wd[1], msk[1]);
      if (wr[0] && (wa[0] == wa[p])) post_w = lane_merge(post_w, wd[0], msk[0]);
      resp[p] = we[p] ? post_w : old_w;
    end

    always_comb begin
      occ_d = occ_q;
      if (push && !pop)      occ_d = occ_q + 2'd1;
      else if (pop && !push) occ_d = occ_q - 2'd1;
    end

    always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
        occ_q  <= 2'd0;
        head_q <= 1'b0;
      end else begin
        occ_q  <= occ_d;
        head_q <= head_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) ent_q[tail] <= resp[p];
    end
  end

endmodule

// File: tb/tb_scalar_memory_bp.sv
// Directed bench for scalar_memory_bp: instance A without write acks,
// instance B with write acks and a depth short of the address space.
module tb_scalar_memory_bp;
  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  logic        a_t0_valid, a_t0_ready, a_t0_we, a_i0_valid, a_i0_ready;
  logic [3:0]  a_t0_mask;
  logic [31:0] a_t0_addr, a_t0_data, a_i0_data;
  logic        a_t1_valid, a_t1_ready, a_t1_we, a_i1_valid, a_i1_ready;
  logic [3:0]  a_t1_mask;
  logic [31:0] a_t1_addr, a_t1_data, a_i1_data;
  logic        b_t0_valid, b_t0_ready, b_t0_we, b_i0_valid, b_i0_ready;
  logic [3:0]  b_t0_mask;
  logic [31:0] b_t0_addr, b_t0_data, b_i0_data;
  logic        b_t1_valid, b_t1_ready, b_t1_we, b_i1_valid, b_i1_ready;
  logic [3:0]  b_t1_mask;
  logic [31:0] b_t1_addr, b_t1_data, b_i1_data;

  scalar_memory_bp #(.DWIDTH(32), .AWIDTH(13), .DEPTH(8192), .WR_ACK(0)) u_a (
    .clk(clk), .srst(srst),
    .t0_valid(a_t0_valid), .t0_ready(a_t0_ready), .t0_we(a_t0_we), .t0_mask(a_t0_mask),
    .t0_addr(a_t0_addr), .t0_data(a_t0_data),
    .i0_valid(a_i0_valid), .i0_ready(a_i0_ready), .i0_data(a_i0_data),
    .t1_valid(a_t1_valid), .t1_ready(a_t1_ready), .t1_we(a_t1_we), .t1_mask(a_t1_mask),
    .t1_addr(a_t1_addr), .t1_data(a_t1_data),
    .i1_valid(a_i1_valid), .i1_ready(a_i1_ready), .i1_data(a_i1_data));

  scalar_memory_bp #(.DWIDTH(32), .AWIDTH(13), .DEPTH(8000), .WR_ACK(1)) u_b (
    .clk(clk), .srst(srst),
    .t0_valid(b_t0_valid), .t0_ready(b_t0_ready), .t0_we(b_t0_we), .t0_mask(b_t0_mask),
    .t0_addr(b_t0_addr), .t0_data(b_t0_data),
    .i0_valid(b_i0_valid), .i0_ready(b_i0_ready), .i0_data(b_i0_data),
    .t1_valid(b_t1_valid), .t1_ready(b_t1_ready), .t1_we(b_t1_we), .t1_mask(b_t1_mask),
    .t1_addr(b_t1_addr), .t1_data(b_t1_data),
    .i1_valid(b_i1_valid), .i1_ready(b_i1_ready), .i1_data(b_i1_data));

  int errors = 0;
  int checks = 0;
  logic [31:0] qa0[$], qa1[$], qb0[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop the oldest expected response on every response handshake.
  always @(negedge clk) begin
    logic [31:0] mexp;
    if (a_i0_valid && a_i0_ready) begin
      checks++;
      assert (qa0.size() != 0) else begin
        errors++; $error("FAIL rsp_a0_extra: observed=%h expected=none", a_i0_data);
      end
      if (qa0.size() != 0) begin
        mexp = qa0.pop_front();
        chk("rsp_a0", a_i0_data, mexp);
      end
    end
    if (a_i1_valid && a_i1_ready) begin
      checks++;
      assert (qa1.size() != 0) else begin
        errors++; $error("FAIL rsp_a1_extra: observed=%h expected=none", a_i1_data);
      end
      if (qa1.size() != 0) begin
        mexp = qa1.pop_front();
        chk("rsp_a1", a_i1_data, mexp);
      end
    end
    if (b_i0_valid && b_i0_ready) begin
      checks++;
      assert (qb0.size() != 0) else begin
        errors++; $error("FAIL rsp_b0_extra: observed=%h expected=none", b_i0_data);
      end
      if (qb0.size() != 0) begin
        mexp = qb0.pop_front();
        chk("rsp_b0", b_i0_data, mexp);
      end
    end
  end

  task automatic drive(input int port, input logic v, input logic we, input logic [3:0] m,
                       input logic [31:0] addr, input logic [31:0] d);
    case (port)
      0: begin a_t0_valid = v; a_t0_we = we; a_t0_mask = m; a_t0_addr = addr; a_t0_data = d; end
      1: begin a_t1_valid = v; a_t1_we = we; a_t1_mask = m; a_t1_addr = addr; a_t1_data = d; end
      default: begin b_t0_valid = v; b_t0_we = we; b_t0_mask = m; b_t0_addr = addr; b_t0_data = d; end
    endcase
  endtask

  function automatic logic rdy_of(input int port);
    case (port)
      0: return a_t0_ready;
      1: return a_t1_ready;
      default: return b_t0_ready;
    endcase
  endfunction

  task automatic push_exp(input int port, input logic [31:0] e);
    case (port)
      0: qa0.push_back(e);
      1: qa1.push_back(e);
      default: qb0.push_back(e);
    endcase
  endtask

  task automatic quiet();
    a_t0_valid = 1'b0; a_t1_valid = 1'b0; b_t0_valid = 1'b0;
  endtask

  // Holds the request until accepted (bounded); leaves valid asserted on return.
  task automatic issue(input int port, input logic we, input logic [3:0] m, input logic [31:0] addr,
                       input logic [31:0] d, input logic exp_en, input logic [31:0] e);
    logic ok;
    ok = 1'b0;
    drive(port, 1'b1, we, m, addr, d);
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (rdy_of(port)) begin
        ok = 1'b1;
        if (exp_en) push_exp(port, e);
      end
      @(posedge clk); #1;
    end
    chk1($sformatf("accept_p%0d", port), ok, 1'b1);
  endtask

  initial begin
    srst = 1'b1;
    a_i0_ready = 1'b1; a_i1_ready = 1'b1; b_i0_ready = 1'b1; b_i1_ready = 1'b1;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
    drive(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    b_t1_valid = 1'b0; b_t1_we = 1'b0; b_t1_mask = 4'h0; b_t1_addr = 32'h0; b_t1_data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_a_i0_valid", a_i0_valid, 1'b0);
    chk1("rst_a_i1_valid", a_i1_valid, 1'b0);
    chk("rst_a_i0_data", a_i0_data, 32'h0);
    chk1("rst_b_i0_valid", b_i0_valid, 1'b0);
    chk1("rst_a_t0_ready_rd", a_t0_ready, 1'b1);
    chk1("rst_a_t1_ready_wr", a_t1_ready, 1'b1);
    chk1("rst_b_t1_ready", b_t1_ready, 1'b1);
    @(posedge clk); #1;
    srst = 1'b0;

    // Byte-mask merge and 1-cycle read latency
    issue(0, 1'b1, 4'b1111, 32'h40, 32'h11223344, 1'b0, 32'h0);
    issue(0, 1'b1, 4'b0101, 32'h40, 32'hAABBCCDD, 1'b0, 32'h0);
    chk1("wr_no_rsp", a_i0_valid, 1'b0);
    issue(0, 1'b0, 4'b0000, 32'h40, 32'h0, 1'b1, 32'h11BB33DD);
    quiet();
    chk1("rd_latency1", a_i0_valid, 1'b1);
    @(posedge clk); #1;

    // Backpressure: two buffered, third stalls, then drains in order
    issue(0, 1'b1, 4'hF, 32'h0, 32'h000000A0, 1'b0, 32'h0);
    issue(0, 1'b1, 4'hF, 32'h4, 32'h000000A4, 1'b0, 32'h0);
    issue(0, 1'b1, 4'hF, 32'h8, 32'h000000A8, 1'b0, 32'h0);
    quiet();
    a_i0_ready = 1'b0;
    issue(0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h000000A0);
    issue(0, 1'b0, 4'h0, 32'h4, 32'h0, 1'b1, 32'h000000A4);
    drive(0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk1("bp_t0_ready_low", a_t0_ready, 1'b0);
      chk("bp_i0_data_stable", a_i0_data, 32'h000000A0);
      @(posedge clk); #1;
    end
    a_i0_ready = 1'b1;
    issue(0, 1'b0, 4'h0, 32'h8, 32'h0, 1'b1, 32'h000000A8);
    quiet();
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drained", qa0.size(), 32'd0);

    // Dual-write collision on one word
    issue(0, 1'b1, 4'hF, 32'h100, 32'h12345678, 1'b0, 32'h0);
    quiet();
    drive(0, 1'b1, 1'b1, 4'b0001, 32'h100, 32'h000000FF);
    drive(1, 1'b1, 1'b1, 4'b0011, 32'h100, 32'h0000EEEE);
    @(negedge clk);
    chk1("coll_t0_ready", a_t0_ready, 1'b1);
    chk1("coll_t1_ready", a_t1_ready, 1'b1);
    @(posedge clk); #1;
    quiet();
    issue(0, 1'b0, 4'h0, 32'h100, 32'h0, 1'b1, 32'h1234EEFF);
    quiet();

    // Cross-port read during write returns old data, next cycle new data
    issue(0, 1'b1, 4'hF, 32'h8, 32'h00000005, 1'b0, 32'h0);
    quiet();
    drive(0, 1'b1, 1'b1, 4'hF, 32'h8, 32'h00000009);
    drive(1, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    @(negedge clk);
    chk1("rdw_t1_ready", a_t1_ready, 1'b1);
    qa1.push_back(32'h00000005);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    @(negedge clk);
    chk1("rdw2_t0_ready", a_t0_ready, 1'b1);
    chk1("rdw2_t1_ready", a_t1_ready, 1'b1);
    qa0.push_back(32'h00000009);
    qa1.push_back(32'h00000009);
    @(posedge clk); #1;
    quiet();

    // Write acks on B, plus the depth boundary
    issue(2, 1'b1, 4'b1111, 32'h20, 32'h0000BEEF, 1'b1, 32'h0000BEEF);
    quiet();
    issue(2, 1'b1, 4'b1100, 32'h20, 32'hCAFE0000, 1'b1, 32'hCAFEBEEF);
    quiet();
    chk1("ack_latency1", b_i0_valid, 1'b1);
    issue(2, 1'b1, 4'hF, 32'h7CFC, 32'h600DF00D, 1'b1, 32'h600DF00D);
    issue(2, 1'b0, 4'h0, 32'h7CFC, 32'h0, 1'b1, 32'h600DF00D);
    issue(2, 1'b1, 4'hF, 32'h7D00, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue(2, 1'b0, 4'h0, 32'h7D00, 32'h0, 1'b1, 32'h0);
    quiet();
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset with two responses buffered
    a_i0_ready = 1'b0;
    issue(0, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0, 32'h0);
    issue(0, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0, 32'h0);
    quiet();
    a_t0_we = 1'b0;
    #2 srst = 1'b1;
    #1;
    chk1("arst_i0_valid", a_i0_valid, 1'b0);
    chk("arst_i0_data", a_i0_data, 32'h0);
    chk1("arst_t0_ready", a_t0_ready, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    srst = 1'b0;
    a_i0_ready = 1'b1;
    issue(0, 1'b0, 4'h0, 32'h80000041, 32'h0, 1'b1, 32'h11BB33DD);
    quiet();

    repeat (5) @(posedge clk);
    #1;
    chk("end_qa0_empty", qa0.size(), 32'd0);
    chk("end_qa1_empty", qa1.size(), 32'd0);
    chk("end_qb0_empty", qb0.size(), 32'd0);
    chk1("b1_silent_valid", b_i1_valid, 1'b0);
    chk("b1_silent_data", b_i1_data, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
